// File: rtl/trade_pkg.sv
// Shared trade-path definitions: sample width default, channel indices and
// the min/max scanner state encoding.
package trade_pkg;
  localparam int PRICE_W_DEF = 8;
  localparam int CH_PRICE    = 0;
  localparam int CH_SPREAD   = 1;

  typedef enum logic {
    SCAN_IDLE = 1'b0,
    SCAN_RUN  = 1'b1
  } scan_state_t;

  // $clog2 that never returns 0, so single-entry selects still get a 1-bit port
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/minmax_scanner.sv
// Background min/max walk over the stored window, newest first, one entry per
// cycle; any write restarts the walk while the last committed result holds.
module minmax_scanner
  import trade_pkg::*;
#(
  parameter int PRICE_W = PRICE_W_DEF,
  parameter int AW      = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               wr,
  input  logic [AW:0]        count,
  input  logic [PRICE_W-1:0] scan_data,
  output logic [AW-1:0]      scan_idx,
  output logic [PRICE_W-1:0] min_out,
  output logic [PRICE_W-1:0] max_out,
  output logic               minmax_valid,
  output logic               scan_busy
);
  scan_state_t        state, state_nxt;
  logic [PRICE_W-1:0] run_min, run_max, nmin, nmax;
  logic               last;

  assign scan_busy = (state == SCAN_RUN);
  assign nmin      = (scan_data < run_min) ? scan_data : run_min;
  assign nmax      = (scan_data > run_max) ? scan_data : run_max;
  assign last      = ({1'b0, scan_idx} == (count - (AW+1)'(1)));

  always_comb begin
    state_nxt = state;
    if (wr)
      state_nxt = SCAN_RUN;
    else if (state == SCAN_RUN && last)
      state_nxt = SCAN_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state        <= SCAN_IDLE;
      scan_idx     <= '0;
      run_min      <= '1;
      run_max      <= '0;
      min_out      <= '0;
      max_out      <= '0;
      minmax_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (wr) begin
        scan_idx <= '0;
        run_min  <= '1;
        run_max  <= '0;
      end else if (state == SCAN_RUN) begin
        run_min  <= nmin;
        run_max  <= nmax;
        scan_idx <= scan_idx + AW'(1);
        if (last) begin
          min_out      <= nmin;
          max_out      <= nmax;
          minmax_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/price_history_buffer.sv
// Multi-channel ring buffer of match-event samples with a newest-first read
// port for the renderer and a background ch0 min/max scan for auto-scaling.
module price_history_buffer
  import trade_pkg::*;
#(
  parameter  int PRICE_W   = PRICE_W_DEF,
  parameter  int NCH       = 2,
  parameter  int DEPTH     = 64,
  parameter  int DECIM     = 1,
  parameter  int EDGE_MODE = 1,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = clog2_min1(NCH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   freeze,
  input  logic                   sample_valid,
  input  logic [NCH*PRICE_W-1:0] sample_data,
  input  logic [AW-1:0]          rd_idx,
  input  logic [CW-1:0]          rd_ch,
  output logic [PRICE_W-1:0]     rd_data,
  output logic                   rd_valid,
  output logic [AW:0]            count,
  output logic                   full,
  output logic [PRICE_W-1:0]     min_out,
  output logic [PRICE_W-1:0]     max_out,
  output logic                   minmax_valid,
  output logic                   scan_busy
);
  localparam int DW = clog2_min1(DECIM);

  logic [NCH-1:0][PRICE_W-1:0] mem [DEPTH];
  logic [NCH-1:0][PRICE_W-1:0] wr_word;
  logic [AW-1:0]               wr_ptr, rd_addr, scan_addr, scan_idx;
  logic [DW-1:0]               dcnt;
  logic                        sv_d, accept, wr, in_range;
  logic [PRICE_W-1:0]          rd_word, scan_data;

  assign wr_word = sample_data;
  assign accept  = ~freeze & ((EDGE_MODE != 0) ? (sample_valid & ~sv_d) : sample_valid);
  assign wr      = accept & (dcnt == DW'(DECIM-1)) & ~reset & ~clear;
  assign full    = (count == (AW+1)'(DEPTH));

  // Newest-first addressing: index 0 is the slot just behind the write pointer
  assign rd_addr   = wr_ptr - AW'(1) - rd_idx;
  assign scan_addr = wr_ptr - AW'(1) - scan_idx;
  assign in_range  = ({1'b0, rd_idx} < count);
  assign rd_word   = (32'(rd_ch) < NCH) ? mem[rd_addr][rd_ch] : '0;
  assign scan_data = mem[scan_addr][CH_PRICE];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sv_d   <= 1'b0;
      dcnt   <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      sv_d <= sample_valid;
      if (accept)
        dcnt <= (dcnt == DW'(DECIM-1)) ? '0 : dcnt + DW'(1);
      if (wr) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (!full)
          count <= count + (AW+1)'(1);
      end
    end
  end

  // Storage is never flushed; count gates every read
  always_ff @(posedge clk) begin
    if (wr)
      mem[wr_ptr] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= in_range;
      rd_data  <= in_range ? rd_word : '0;
    end
  end

  minmax_scanner #(.PRICE_W(PRICE_W), .AW(AW)) u_scan (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .wr           (wr),
    .count        (count),
    .scan_data    (scan_data),
    .scan_idx     (scan_idx),
    .min_out      (min_out),
    .max_out      (max_out),
    .minmax_valid (minmax_valid),
    .scan_busy    (scan_busy)
  );
endmodule

// File: tb/tb_price_history_buffer.sv
// Four buffer configurations share one stimulus stream; a newest-first history
// model per configuration is compared against every output on every cycle.
module tb_price_history_buffer;
  localparam int NI = 4;

  function automatic int dep_of(input int i);
    return (i == 2) ? 4 : 64;
  endfunction
  function automatic int dec_of(input int i);
    return (i == 3) ? 3 : 1;
  endfunction
  function automatic int edg_of(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  logic        clk = 1'b0;
  logic        reset, clear, freeze, sample_valid;
  logic [15:0] sample_data;
  logic [5:0]  rd_idx;
  logic [0:0]  rd_ch;

  logic [7:0] rd_data_w [NI];
  logic       rd_valid_w [NI];
  logic [6:0] count_w [NI];
  logic       full_w [NI];
  logic [7:0] min_w [NI];
  logic [7:0] max_w [NI];
  logic       mmv_w [NI];
  logic       busy_w [NI];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int D   = dep_of(g);
    localparam int AWG = $clog2(D);
    logic [AWG:0] cnt;
    price_history_buffer #(
      .PRICE_W(8), .NCH(2), .DEPTH(D), .DECIM(dec_of(g)), .EDGE_MODE(edg_of(g))
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .clear        (clear),
      .freeze       (freeze),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .rd_idx       (rd_idx[AWG-1:0]),
      .rd_ch        (rd_ch),
      .rd_data      (rd_data_w[g]),
      .rd_valid     (rd_valid_w[g]),
      .count        (cnt),
      .full         (full_w[g]),
      .min_out      (min_w[g]),
      .max_out      (max_w[g]),
      .minmax_valid (mmv_w[g]),
      .scan_busy    (busy_w[g])
    );
    assign count_w[g] = 7'(cnt);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: h[i][k] is the k-th newest stored sample; scan result is due
  // count cycles after the last write.
  logic [15:0] h [NI][64];
  int          sz [NI], dcnt_m [NI], left_m [NI];
  bit          svd_m [NI], busy_m [NI], mmv_m [NI], rdv_m [NI];
  logic [7:0]  mn_m [NI], mx_m [NI], rdd_m [NI];

  always @(posedge clk) begin
    int  ix;
    bit  acc, wr;
    for (int i = 0; i < NI; i++) begin
      if (reset || clear) begin
        sz[i] = 0; dcnt_m[i] = 0; left_m[i] = 0; svd_m[i] = 0;
        busy_m[i] = 0; mmv_m[i] = 0; rdv_m[i] = 0;
        mn_m[i] = 0; mx_m[i] = 0; rdd_m[i] = 0;
      end else begin
        ix = int'(rd_idx) % dep_of(i);
        rdv_m[i] = (ix < sz[i]);
        rdd_m[i] = !rdv_m[i] ? 8'd0 : (rd_ch[0] ? h[i][ix][15:8] : h[i][ix][7:0]);
        acc = !freeze && (edg_of(i) != 0 ? (sample_valid && !svd_m[i]) : sample_valid);
        svd_m[i] = sample_valid;
        wr = 0;
        if (acc) begin
          if (dcnt_m[i] == dec_of(i) - 1) begin wr = 1; dcnt_m[i] = 0; end
          else dcnt_m[i]++;
        end
        if (wr) begin
          for (int k = 63; k > 0; k--) h[i][k] = h[i][k-1];
          h[i][0] = sample_data;
          if (sz[i] < dep_of(i)) sz[i]++;
          busy_m[i] = 1;
          left_m[i] = sz[i];
        end else if (busy_m[i]) begin
          left_m[i]--;
          if (left_m[i] == 0) begin
            mn_m[i] = 8'hFF; mx_m[i] = 8'h00;
            for (int k = 0; k < sz[i]; k++) begin
              if (h[i][k][7:0] < mn_m[i]) mn_m[i] = h[i][k][7:0];
              if (h[i][k][7:0] > mx_m[i]) mx_m[i] = h[i][k][7:0];
            end
            mmv_m[i] = 1; busy_m[i] = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("i%0d rd_data", i),  rd_data_w[i],  rdd_m[i]);
        chk($sformatf("i%0d rd_valid", i), rd_valid_w[i], rdv_m[i]);
        chk($sformatf("i%0d count", i),    count_w[i],    sz[i]);
        chk($sformatf("i%0d full", i),     full_w[i],     sz[i] == dep_of(i));
        chk($sformatf("i%0d min", i),      min_w[i],      mn_m[i]);
        chk($sformatf("i%0d max", i),      max_w[i],      mx_m[i]);
        chk($sformatf("i%0d mmv", i),      mmv_w[i],      mmv_m[i]);
        chk($sformatf("i%0d busy", i),     busy_w[i],     busy_m[i]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle strobe; the write lands on the first edge, returns one edge later
  task automatic strobe(input logic [15:0] d);
    sample_valid = 1'b1;
    sample_data  = d;
    step(1);
    sample_valid = 1'b0;
    step(1);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; freeze = 1'b0; sample_valid = 1'b0;
    sample_data = '0; rd_idx = '0; rd_ch = '0;
    step(1);
    chk_en = 1'b1;
    step(1);
    reset = 1'b0;
    chk("rst count", count_w[0], 0);
    chk("rst mmv", mmv_w[0], 0);
    chk("rst rd_valid", rd_valid_w[0], 0);

    // 10, 20, 5 then the scan: restart keeps old 10/10 until final commit
    strobe(16'h010A);
    strobe(16'h0214);
    strobe(16'h0305);
    step(1);
    chk("restart busy", busy_w[0], 1);
    chk("restart old min", min_w[0], 10);
    chk("restart old max", max_w[0], 10);
    step(1);
    chk("scan3 min", min_w[0], 5);
    chk("scan3 max", max_w[0], 20);
    chk("scan3 mmv", mmv_w[0], 1);
    chk("scan3 count", count_w[0], 3);
    for (int k = 0; k < 4; k++) begin
      rd_idx = 6'(k);
      step(1);
      chk($sformatf("rd3 idx%0d data", k), rd_data_w[0], (k == 0) ? 5 : (k == 1) ? 20 : (k == 2) ? 10 : 0);
      chk($sformatf("rd3 idx%0d valid", k), rd_valid_w[0], k < 3);
    end
    rd_idx = 0; rd_ch = 1;
    step(1);
    chk("rd3 ch1", rd_data_w[0], 3);
    rd_ch = 0;

    // Held strobe: one write with edge capture, ten with level capture
    do_clear();
    sample_valid = 1'b1; sample_data = 16'h0707;
    step(10);
    sample_valid = 1'b0;
    chk("edge1 count", count_w[0], 1);
    chk("edge0 count", count_w[1], 10);
    chk("d4 full", full_w[2], 1);
    step(12);

    // Depth 4 keeps the newest four of 1..6
    do_clear();
    for (int v = 1; v <= 6; v++) strobe(16'((v + 16) << 8 | v));
    step(5);
    chk("d4 count", count_w[2], 4);
    chk("d4 full2", full_w[2], 1);
    chk("d4 min", min_w[2], 3);
    chk("d4 max", max_w[2], 6);
    for (int k = 0; k < 4; k++) begin
      rd_idx = 6'(k);
      step(1);
      chk($sformatf("d4 idx%0d", k), rd_data_w[2], 6 - k);
    end
    rd_idx = 0;

    // Decimation by 3, then freeze holds both count and phase
    do_clear();
    for (int v = 1; v <= 7; v++) strobe(16'(v));
    chk("dec count", count_w[3], 2);
    step(1);
    chk("dec idx0", rd_data_w[3], 6);
    rd_idx = 1;
    step(1);
    chk("dec idx1", rd_data_w[3], 3);
    rd_idx = 0;
    freeze = 1'b1;
    for (int v = 8; v <= 12; v++) strobe(16'(v));
    freeze = 1'b0;
    chk("frz dec count", count_w[3], 2);
    chk("frz dec1 count", count_w[0], 7);
    strobe(16'd13);
    chk("frz phase count", count_w[3], 2);
    strobe(16'd14);
    chk("post frz count", count_w[3], 3);
    step(1);
    chk("post frz idx0", rd_data_w[3], 14);

    // Clear mid-scan with a strobe: everything zero and the sample dropped
    strobe(16'h0050);
    strobe(16'h0060);
    chk("pre-clr busy", busy_w[0], 1);
    sample_valid = 1'b1; sample_data = 16'h0070; clear = 1'b1;
    step(1);
    sample_valid = 1'b0; clear = 1'b0;
    chk("clr count", count_w[0], 0);
    chk("clr busy", busy_w[0], 0);
    chk("clr mmv", mmv_w[0], 0);
    chk("clr max", max_w[0], 0);
    step(1);
    chk("clr dropped", count_w[0], 0);

    // Reads overlapping writes, across channels and past the fill level
    for (int k = 0; k < 24; k++) begin
      rd_idx = 6'((k * 5) % 8);
      rd_ch  = 1'(k % 2);
      strobe(16'(k * 37 + 3));
    end
    step(70);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
